// File: rtl/uart_arb_pkg.sv
// Shared types, constants and round-robin helper for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } arb_state_t;

  localparam logic [3:0]  HDR_TAG = 4'hA;
  localparam int unsigned ID_W    = 3;
  localparam int unsigned MAX_REQ = 8;

  // First set bit of valid searching upward from ptr+1, wrapping modulo n.
  function automatic logic [ID_W-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr,
                                              input int unsigned        n);
    logic [ID_W-1:0] pick;
    logic            found;
    int unsigned     idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      idx = (32'(ptr) + i) % n;
      if (!found && (i <= n) && valid[idx[ID_W-1:0]]) begin
        pick  = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin grant index from the live request vector.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]    req_valid_i,
  input  logic [ID_W-1:0] rr_ptr_i,
  output logic [ID_W-1:0] grant_idx_c,
  output logic            any_valid_c
);

  always_comb begin
    grant_idx_c = rr_pick(MAX_REQ'(req_valid_i), rr_ptr_i, N);
    any_valid_c = |req_valid_i;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter feeding one buffered UART transmitter,
// with optional per-packet channel header and MAX_LEN grant truncation.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter bit          HEADER_EN = 1'b1,
  parameter int unsigned MAX_LEN   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_en,
  input  logic                 tx_full,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 pkt_trunc
);

  localparam int unsigned     LEN_W    = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [LEN_W-1:0] len_cnt_q, len_cnt_d;

  logic [ID_W-1:0]  pick_c;
  logic             any_valid_c;
  logic [7:0]       sel_data;
  logic             sel_valid;
  logic             sel_last;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_idx_c (pick_c),
    .any_valid_c (any_valid_c)
  );

  // Grantee's byte lane, valid and last.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        sel_data  = req_data[8*i +: 8];
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    len_cnt_d  = len_cnt_q;
    tx_data    = '0;
    tx_en      = 1'b0;
    req_ready  = '0;
    pkt_trunc  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_valid_c) begin
          grant_id_d = pick_c;
          rr_ptr_d   = pick_c;
          len_cnt_d  = '0;
          state_d    = HEADER_EN ? HEADER : PAYLOAD;
        end
      end

      HEADER: begin
        tx_data = {HDR_TAG, 1'b0, grant_id_q};
        tx_en   = !tx_full;
        if (!tx_full) state_d = PAYLOAD;
      end

      PAYLOAD: begin
        tx_data   = sel_data;
        req_ready = NUM_REQ'(!tx_full) << grant_id_q;
        tx_en     = sel_valid && !tx_full;
        if (tx_en) begin
          len_cnt_d = len_cnt_q + LEN_W'(1);
          if (sel_last) begin
            state_d = IDLE;
          end else if (len_cnt_q == LEN_LAST) begin
            // Forced release; the remainder re-arbitrates as a new packet.
            state_d   = IDLE;
            pkt_trunc = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // No buffer writes or handshakes while reset is being applied.
    if (!rst_n) begin
      tx_en     = 1'b0;
      req_ready = '0;
      pkt_trunc = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= ID_W'(NUM_REQ - 1);
      grant_id_q <= '0;
      len_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      len_cnt_q  <= len_cnt_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign grant_id = grant_id_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one buffered UART transmitter between NUM_REQ independent byte-stream requesters.
- Arbitration is round-robin and packet-atomic. Once a requester is granted, all of its bytes up to and including the one flagged last are written into the transmit buffer uninterrupted.
- Optionally prefixes each packet with a one-byte channel header.
- Sits directly in front of the transmit side of the buffered UART: drives its tx_data/tx_en and obeys its tx_full.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- HEADER_EN, 1, 1 = emit header byte {4'hA, 1'b0, id[2:0]} before each packet's payload
- MAX_LEN, 64, maximum payload bytes per grant; the grant is force-released after this many bytes

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_data  in  NUM_REQ*8  payload byte of requester i at bits [8i+7:8i]
- req_valid  in  NUM_REQ  requester i has a byte available
- req_last  in  NUM_REQ  byte of requester i is the last of its packet
- req_ready  out  NUM_REQ  byte of requester i is accepted this cycle when valid&ready
- tx_data  out  8  byte to the UART transmit buffer
- tx_en  out  1  write strobe to the UART transmit buffer
- tx_full  in  1  UART transmit buffer full
- busy  out  1  a grant is active (state != IDLE)
- grant_id  out  3  index of the current or most recent grantee
- pkt_trunc  out  1  one-cycle pulse when a grant is released because MAX_LEN was reached without last

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low, on rst_n. All state updates on the rising clk edge.
- Reset values: state=IDLE, rr_ptr=NUM_REQ-1, len_cnt=0, grant_id=0, busy=0, pkt_trunc=0, tx_en=0, req_ready=0, tx_data=0.
- Reset mid-packet: returns to IDLE on the next edge. The buffer receives no further writes. A partially sent packet is not completed.
- FSM states: IDLE, HEADER, PAYLOAD.
- IDLE, arbitration:
  - If any req_valid is set, pick the first set index searching from rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - Register grant_id and set rr_ptr to that index. Clear len_cnt.
  - Go to HEADER if HEADER_EN=1, else go to PAYLOAD.
  - No tx_en and no req_ready in IDLE. Arbitration costs one cycle.
- HEADER:
  - tx_data = {4'hA, 1'b0, grant_id}, tx_en = ~tx_full.
  - Go to PAYLOAD on the cycle where tx_en=1. Otherwise hold in HEADER.
- PAYLOAD, per-byte handshake:
  - req_ready[grant_id] = ~tx_full. All other req_ready bits are 0.
  - tx_data = req_data[grant_id] (combinational pass-through, zero latency).
  - tx_en = req_valid[grant_id] & ~tx_full.
  - Each accepted byte increments len_cnt.
  - A gap in req_valid from the grantee holds the grant indefinitely. There is no idle timeout.
- PAYLOAD exits:
  - Accepted byte with req_last[grant_id]=1: go to IDLE.
  - Accepted byte with len_cnt reaching MAX_LEN and last=0: go to IDLE and pulse pkt_trunc on that same cycle. The requester's remaining bytes form a new packet under later arbitration.
  - A byte that is both last and the MAX_LEN-th: normal end, no pkt_trunc.
- Buffer protection: tx_en is never asserted while tx_full=1. The buffer must never see a write when full.
- Fairness: after a grant to i, i has lowest priority in the next arbitration.
  - Example, NUM_REQ=4, grant to 2: next priority order is 3, 0, 1, 2.
- Simultaneous requests in IDLE: resolved purely by the rr_ptr search order.
- Requests arriving during an active grant: wait. They see req_ready=0.
- Valid that drops before grant: if req_valid[i] falls while in IDLE-pending, only the current-cycle vector is used. There is no request latching.
- len_cnt width: $clog2(MAX_LEN+1). It must never wrap.
- Throughput:
  - Back-to-back packets incur 1 idle cycle (IDLE) plus 1 header cycle when HEADER_EN=1.
  - Payload rate is 1 byte per clk while tx_full=0.

Decomposition:
- Package uart_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} arb_state_t
  - constant HDR_TAG = 4'hA
  - function rr_pick(valid vector, pointer) returning the next grant index.
- Sub-module rr_arbiter (parameter N) computes the round-robin grant index combinationally from req_valid and rr_ptr. The FSM, length counter and datapath mux stay in uart_tx_arbiter.
- Top-level integration connects tx_data/tx_en/tx_full to the buffered UART's transmit port.

Test Plan:
- Single packet: NUM_REQ=4, HEADER_EN=1, req 1 sends 3 bytes 0x11,0x22,0x33 (last on 0x33), tx_full=0 -> buffer receives 0xA1,0x11,0x22,0x33 on 4 consecutive cycles after 1 IDLE cycle; busy falls after the last byte.
- Round-robin: reqs 0,1,3 all valid with 2-byte packets from reset -> grant order 0,1,3, then 0 again; headers 0xA0,0xA1,0xA3; no interleaving of payload bytes.
- Backpressure: tx_full=1 for 5 cycles mid-payload of req 2 -> tx_en=0 and req_ready[2]=0 for those 5 cycles; no bytes lost or duplicated; byte order preserved.
- Truncation: MAX_LEN=4, req 0 streams 6 bytes with last only on byte 6 -> pkt_trunc pulses with byte 4; the grant goes to another valid requester if present; req 0's bytes 5-6 are sent later under a new header 0xA0.
- HEADER_EN=0 with simultaneous last and MAX_LEN: a 4-byte packet with last on byte 4 -> no pkt_trunc; exactly 4 writes.
- Reset mid-packet: rst_n low for 1 cycle during PAYLOAD of req 3 -> next cycle all outputs at reset values; first grant after reset goes to req 0 when reqs 0 and 3 are both valid.
